// File: rtl/hc595_frame_shifter_if.sv
// Frame request and 74HC595 pin bundle for hc595_frame_shifter.
//   start   : single-cycle request to send a frame
//   data_in : frame, MSB shifted first
//   busy    : frame in progress
//   done    : one-cycle pulse once the frame is latched
//   sclk    : 74HC595 SHCP (shift clock)
//   sdata   : 74HC595 DS (serial data)
//   rclk    : 74HC595 STCP (storage latch)
// master: the requester, which also observes the pins. slave: the shifter.
interface hc595_frame_shifter_if #(
  parameter int unsigned FRAME_W = 16
);
  logic               start;
  logic [FRAME_W-1:0] data_in;
  logic               busy;
  logic               done;
  logic               sclk;
  logic               sdata;
  logic               rclk;

  modport master (
    output start,
    output data_in,
    input  busy,
    input  done,
    input  sclk,
    input  sdata,
    input  rclk
  );

  modport slave (
    input  start,
    input  data_in,
    output busy,
    output done,
    output sclk,
    output sdata,
    output rclk
  );
endinterface

// File: rtl/hc595_frame_shifter.sv
// Serial output stage for a daisy-chained pair of 74HC595 shift registers.
// On an accepted start the 16-bit frame is captured and shifted out MSB-first
// on sdata/sclk, then latched with an rclk pulse and flagged with done.
// sclk half-period and rclk width are CLK_DIV clk cycles (legal 1..255).
// Ports:
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : slave side of hc595_frame_shifter_if (start, data_in, busy, done,
//         sclk, sdata, rclk)
// Every pin is driven straight from a flop; the flop inputs are decoded from
// the next state so pins change on the same edge as the state.
module hc595_frame_shifter #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned FRAME_W = 16
) (
  input logic                   clk,
  input logic                   rst,
  hc595_frame_shifter_if.slave  bus
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StShiftLo = 3'd1;
  localparam logic [2:0] StShiftHi = 3'd2;
  localparam logic [2:0] StLatch   = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  localparam logic [7:0] TickMax   = 8'(CLK_DIV - 1);
  localparam logic [3:0] LastBit   = 4'(FRAME_W - 1);

  logic [2:0]         state_q, state_d;
  logic [7:0]         tick_q, tick_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic               sdata_q, sdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sclk_q, sclk_d;
  logic               rclk_q, rclk_d;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    sdata_d   = sdata_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          shreg_d   = bus.data_in;
          sdata_d   = bus.data_in[FRAME_W-1];
          bit_cnt_d = 4'd0;
          tick_d    = 8'd0;
          state_d   = StShiftLo;
        end
      end
      StShiftLo: begin
        if (tick_q == TickMax) begin
          tick_d  = 8'd0;
          state_d = StShiftHi;
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end
      StShiftHi: begin
        if (tick_q == TickMax) begin
          tick_d = 8'd0;
          if (bit_cnt_q == LastBit) begin
            state_d = StLatch;
          end else begin
            // Next bit is presented on the falling sclk edge so it is stable
            // for a full half-period before the following rising edge.
            bit_cnt_d = bit_cnt_q + 4'd1;
            shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
            sdata_d   = shreg_q[FRAME_W-2];
            state_d   = StShiftLo;
          end
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end
      StLatch: begin
        if (tick_q == TickMax) begin
          tick_d  = 8'd0;
          state_d = StDone;
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
    sclk_d = (state_d == StShiftHi);
    rclk_d = (state_d == StLatch);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      tick_q    <= 8'd0;
      bit_cnt_q <= 4'd0;
      shreg_q   <= '0;
      sdata_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      rclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      sdata_q   <= sdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      rclk_q    <= rclk_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sclk  = sclk_q;
  assign bus.sdata = sdata_q;
  assign bus.rclk  = rclk_q;

endmodule
